fifo_wr_arbiter: RTL

//  Round-robin arbiter that shares the write port of Asy_Fifo among NUM_REQ requesters.

---
 rtl/fifo_wr_arbiter.sv | 141 ++++++++++++++
 1 files changed

// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing the Asy_Fifo write port among NUM_REQ requesters.
// Grants one requester for a burst of up to MAX_BURST words, throttled by Wr_Full.
module fifo_wr_arbiter #(
    parameter int NUM_REQ   = 4,
    parameter int Width     = 4,
    parameter int MAX_BURST = 8,
    localparam int GW       = $clog2(NUM_REQ),
    localparam int BW       = $clog2(MAX_BURST + 1)
) (
    input  logic                     Wr_clk,
    input  logic                     reset,
    input  logic [NUM_REQ-1:0]       Req,
    input  logic [NUM_REQ*Width-1:0] Req_data,
    input  logic                     Wr_Full,
    output logic [NUM_REQ-1:0]       Ack,
    output logic                     Fifo_wr_en,
    output logic [Width-1:0]         Fifo_data_in,
    output logic [GW-1:0]            Grant_id,
    output logic                     Busy
);

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_XFER = 1'b1
    } state_t;

    state_t          r_state;
    logic [GW-1:0]   r_rr_ptr;
    logic [GW-1:0]   r_grant_id;
    logic [BW-1:0]   r_burst_cnt;

    logic            w_xfer;
    logic            w_req_g;
    logic            w_wr;
    logic            w_last;
    logic            w_exit;
    logic [GW-1:0]   w_pick;
    logic [GW-1:0]   w_next_ptr;
    logic [Width-1:0] w_sel_data;

    // First set request searching upward from ptr, wrapping modulo NUM_REQ.
    function automatic logic [GW-1:0] rr_pick(input logic [NUM_REQ-1:0] req,
                                              input logic [GW-1:0]      ptr);
        logic [GW:0]   cand;
        logic          found;
        logic [GW-1:0] pick;
        found = 1'b0;
        pick  = ptr;
        cand  = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            cand = {1'b0, ptr} + (GW+1)'(i);
            if (cand >= (GW+1)'(NUM_REQ)) begin
                cand = cand - (GW+1)'(NUM_REQ);
            end else begin
                cand = cand;
            end
            if (!found && req[cand[GW-1:0]]) begin
                found = 1'b1;
                pick  = cand[GW-1:0];
            end else begin
                found = found;
            end
        end
        return pick;
    endfunction

    assign w_xfer     = (r_state == S_XFER);
    assign w_req_g    = Req[r_grant_id];
    // A synchronous reset still blocks the write in the cycle it is asserted.
    assign w_wr       = w_xfer & w_req_g & ~Wr_Full & ~reset;
    assign w_last     = (r_burst_cnt == BW'(MAX_BURST - 1));
    assign w_exit     = w_xfer & (~w_req_g | (w_wr & w_last));
    assign w_pick     = rr_pick(Req, r_rr_ptr);
    assign w_next_ptr = (r_grant_id == GW'(NUM_REQ - 1)) ? GW'(0) : r_grant_id + GW'(1);

    // Select the granted requester's data slice.
    always_comb begin
        w_sel_data = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (r_grant_id == GW'(i)) begin
                w_sel_data = Req_data[i*Width +: Width];
            end else begin
                w_sel_data = w_sel_data;
            end
        end
    end

    // Write-side outputs: only the granted requester can be acknowledged.
    always_comb begin
        Ack = '0;
        if (w_wr) begin
            Ack[r_grant_id] = 1'b1;
            Fifo_data_in    = w_sel_data;
        end else begin
            Fifo_data_in    = '0;
        end
    end

    assign Fifo_wr_en = w_wr;
    assign Grant_id   = r_grant_id;
    assign Busy       = w_xfer & ~reset;

    // Arbitration / burst FSM.
    always_ff @(posedge Wr_clk) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_rr_ptr    <= '0;
            r_grant_id  <= '0;
            r_burst_cnt <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (|Req) begin
                        r_grant_id  <= w_pick;
                        r_burst_cnt <= '0;
                        r_state     <= S_XFER;
                    end else begin
                        r_state     <= S_IDLE;
                    end
                end
                S_XFER: begin
                    if (w_wr) begin
                        r_burst_cnt <= r_burst_cnt + BW'(1);
                    end else begin
                        r_burst_cnt <= r_burst_cnt;
                    end
                    if (w_exit) begin
                        r_state  <= S_IDLE;
                        r_rr_ptr <= w_next_ptr;
                    end else begin
                        r_state  <= S_XFER;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
